// File: rtl/rv_pkg.sv
// ============================================================================
// Module  : rv_pkg
// Purpose : Shared types and constants for the ready/valid skid FIFO.
//           Holds the occupancy-state encoding used by rv_skid_fifo and the
//           width of the optional statistics counters.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  // Occupancy state of the FIFO; outputs are decoded from this register only.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } rv_state_e;

  // Width of the optional transfer/stall statistics counters.
  localparam int RV_STAT_W = 32;

endpackage : rv_pkg

`default_nettype wire

// File: rtl/rv_fifo_mem.sv
// ============================================================================
// Module  : rv_fifo_mem
// Purpose : DEPTH x DW flop-array storage for rv_skid_fifo. One synchronous
//           write port and one asynchronous read port. Contents are not reset.
// Ports   : clk_i    in   1       clock, rising edge
//           we_i     in   1       write enable
//           waddr_i  in   AW      write address
//           wdata_i  in   DW      write data
//           raddr_i  in   AW      read address
//           rdata_o  out  DW      read data (combinational from raddr_i)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_fifo_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int c_AW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [c_AW-1:0] waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [c_AW-1:0] raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] r_mem [DEPTH];

  // Storage has no reset: validity is tracked entirely by the controller.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule : rv_fifo_mem

`default_nettype wire

// File: rtl/rv_skid_fifo.sv
// ============================================================================
// Module  : rv_skid_fifo
// Purpose : Parametrised ready/valid elastic buffer. DEPTH-entry FIFO between
//           a producer (s_*) and a consumer (m_*) port. All handshake outputs
//           are decoded from registered state, so there is no combinational
//           path from s_* to m_* nor from m_ready_i to s_ready_o.
// Ports   : clk_i        in   1     clock, rising edge
//           rst_ni       in   1     asynchronous active-low reset
//           flush_i      in   1     synchronous flush, discards all entries
//           s_valid_i    in   1     producer valid
//           s_ready_o    out  1     FIFO can accept (not FULL)
//           s_data_i     in   DW    producer payload
//           m_valid_o    out  1     head entry valid (not EMPTY)
//           m_ready_i    in   1     consumer accepts head
//           m_data_o     out  DW    head payload, zero when m_valid_o=0
//           count_o      out  CW    occupancy 0..DEPTH
//           xfer_cnt_o   out  32    completed pops       (RV_FIFO_STATS_EN)
//           stall_cnt_o  out  32    producer stall cycles (RV_FIFO_STATS_EN)
// Config  : define RV_FIFO_STATS_EN to add the saturating statistics counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_skid_fifo
  import rv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DW-1:0]        s_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DW-1:0]        m_data_o,
  output logic [CW-1:0]        count_o
`ifdef RV_FIFO_STATS_EN
  ,
  output logic [RV_STAT_W-1:0] xfer_cnt_o,
  output logic [RV_STAT_W-1:0] stall_cnt_o
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter check
  // --------------------------------------------------------------------------
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("rv_skid_fifo: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and handshake decode
  // --------------------------------------------------------------------------
  rv_state_e            r_state;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_we;
  logic [DW-1:0]        w_rdata;

  assign s_ready_o = (r_state != FULL);
  assign m_valid_o = (r_state != EMPTY);

  assign w_push = s_valid_i & s_ready_o;
  assign w_pop  = m_valid_o & m_ready_i;

  // A push coinciding with a flush is discarded, so it must not be written.
  assign w_we   = w_push & ~flush_i;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  rv_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .waddr_i (r_wr_ptr),
    .wdata_i (s_data_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_rdata)
  );

  // Head data is forced to zero when nothing valid is presented so stale
  // storage contents never leak onto the bus.
  assign m_data_o = m_valid_o ? w_rdata : '0;
  assign count_o  = r_count;

  // --------------------------------------------------------------------------
  // Controller FSM: state, pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= EMPTY;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      // A pop in this cycle was already visible on m_*; it is simply not
      // presented again because the whole FIFO empties here.
      r_state  <= EMPTY;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end

      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_push && !w_pop && (r_count == CW'(DEPTH - 1))) begin
            r_state <= FULL;
          end else if (w_pop && !w_push && (r_count == CW'(1))) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_state <= BUSY;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

`ifdef RV_FIFO_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating statistics; cleared by reset only, flush leaves them intact.
  // --------------------------------------------------------------------------
  logic [RV_STAT_W-1:0] r_xfer_cnt;
  logic [RV_STAT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_xfer_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && (r_xfer_cnt != '1)) begin
        r_xfer_cnt <= r_xfer_cnt + RV_STAT_W'(1);
      end
      if (s_valid_i && !s_ready_o && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + RV_STAT_W'(1);
      end
    end
  end

  assign xfer_cnt_o  = r_xfer_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule : rv_skid_fifo

`default_nettype wire
